mem_word_arbiter: RTL and testbench

- Sits between the processor's two memory clients (port 0 = instruction fetch, port 1 = data load/store) and the byte-wide external memory.
- Arbitrates word requests from the two clients.
- Sequences each 32-bit word access into four byte accesses on the memory's memread/memwrite/mar/writedata/memdata interface.
- Stops granting new transactions once the memory raises its end-of-program flag (kraj).

---
 rtl/mem_word_arbiter_if.sv | 35 +++
 rtl/mem_word_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_word_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_word_arbiter_if.sv
// Bundled client, memory-bus and status signals of mem_word_arbiter.
// slave = arbiter view, master = clients plus external memory.
interface mem_word_arbiter_if #(
   parameter int WIDTH = 8
);
   logic                 req0;
   logic                 we0;
   logic [WIDTH-1:0]     addr0;
   logic [4*WIDTH-1:0]   wdata0;
   logic                 ack0;
   logic                 req1;
   logic                 we1;
   logic [WIDTH-1:0]     addr1;
   logic [4*WIDTH-1:0]   wdata1;
   logic                 ack1;
   logic [4*WIDTH-1:0]   rdata;
   logic                 memread;
   logic                 memwrite;
   logic [WIDTH-1:0]     mar;
   logic [WIDTH-1:0]     writedata;
   logic [WIDTH-1:0]     memdata;
   logic                 kraj;
   logic                 busy;
   logic                 halted;

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, memdata, kraj,
      output ack0, ack1, rdata, memread, memwrite, mar, writedata, busy, halted
   );

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, memdata, kraj,
      input  ack0, ack1, rdata, memread, memwrite, mar, writedata, busy, halted
   );
endinterface

// File: rtl/mem_word_arbiter.sv
// Two-client word arbiter sequencing 32-bit accesses as four big-endian byte accesses.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-1 priority.
module mem_word_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_word_arbiter_if.slave bus
);

   typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAPT, DONE} state_t;

   state_t                    state, next;
   logic [1:0]                idx;
   logic [WIDTH-3:0]          base;
   logic [3:0][WIDTH-1:0]     wbuf;
   logic [3:1][WIDTH-1:0]     rbuf;
   logic [4*WIDTH-1:0]        rdata_q;
   logic                      gnt_id;
   logic                      gnt_pick;
   logic                      halted_q;
   logic                      start;
   logic [WIDTH-1:0]          sel_addr;
   logic                      unused_addr_lsb;

   logic                      memread, memwrite, ack0, ack1;
   logic [WIDTH-1:0]          mar, writedata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                      rr_ptr;

   always_comb begin
      gnt_pick = bus.req1;
      if (bus.req0 && bus.req1)
         gnt_pick = rr_ptr;
   end
`else
   always_comb gnt_pick = bus.req1;
`endif

   // kraj seen in the same IDLE cycle already blocks the grant
   assign start    = (state == IDLE) && !halted_q && !bus.kraj && (bus.req0 || bus.req1);
   assign sel_addr = gnt_pick ? bus.addr1 : bus.addr0;
   assign unused_addr_lsb = ^sel_addr[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next;
   end

   always_comb begin
      next      = state;
      memread   = 1'b0;
      memwrite  = 1'b0;
      mar       = '0;
      writedata = '0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               next = (gnt_pick ? bus.we1 : bus.we0) ? WR : RD_ADDR;
         end
         WR: begin
            memwrite  = 1'b1;
            mar       = {base, idx};
            writedata = wbuf[~idx];
            if (idx == 2'd3)
               next = DONE;
         end
         RD_ADDR: begin
            memread = 1'b1;
            mar     = {base, idx};
            next    = RD_CAPT;
         end
         RD_CAPT: begin
            mar  = {base, idx};
            next = (idx == 2'd3) ? DONE : RD_ADDR;
         end
         DONE: begin
            ack0 = !gnt_id;
            ack1 = gnt_id;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         base     <= '0;
         wbuf     <= '0;
         rbuf     <= '0;
         rdata_q  <= '0;
         gnt_id   <= 1'b0;
         halted_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         rr_ptr   <= 1'b0;
`endif
      end else begin
         halted_q <= halted_q | bus.kraj;
         if (start) begin
            gnt_id <= gnt_pick;
            base   <= sel_addr[WIDTH-1:2];
            wbuf   <= gnt_pick ? bus.wdata1 : bus.wdata0;
            idx    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr <= ~gnt_pick;
`endif
         end
         if (state == WR)
            idx <= idx + 2'd1;
         if (state == RD_CAPT) begin
            idx <= idx + 2'd1;
            // last byte goes straight into rdata so it is valid on entry to DONE
            if (idx == 2'd3)
               rdata_q <= {rbuf, bus.memdata};
            else
               rbuf[~idx] <= bus.memdata;
         end
      end
   end

   assign bus.memread   = memread;
   assign bus.memwrite  = memwrite;
   assign bus.mar       = mar;
   assign bus.writedata = writedata;
   assign bus.ack0      = ack0;
   assign bus.ack1      = ack1;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = (state != IDLE);
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_mem_word_arbiter.sv
// Directed bench for mem_word_arbiter with a byte-wide memory model (one-cycle read latency).
module tb_mem_word_arbiter;

   logic clk;
   logic rst_n;
   int   total;
   int   passed;

   mem_word_arbiter_if #(.WIDTH(8)) bus ();

   mem_word_arbiter #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] mem [256];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.memwrite) mem[bus.mar] <= bus.writedata;
      if (bus.memread)  bus.memdata <= mem[bus.mar];
   end

   typedef struct {
      logic        port;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_req(input logic port, input logic req, input logic we,
                          input logic [7:0] addr, input logic [31:0] wdata);
      if (port) begin
         bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
      end else begin
         bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
      end
   endtask

   task automatic do_reset(input bit chk);
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
      bus.kraj = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (chk) begin
         check("rst_ack0", bus.ack0, 0);
         check("rst_ack1", bus.ack1, 0);
         check("rst_rdata", bus.rdata, 0);
         check("rst_strobes", {bus.memread, bus.memwrite}, 0);
         check("rst_mar", bus.mar, 0);
         check("rst_writedata", bus.writedata, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_halted", bus.halted, 0);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Starts in IDLE (#1 after an edge); returns in the IDLE cycle after the ack.
   task automatic run_txn(input logic port, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input int kraj_at);
      int   lat;
      int   i;
      logic a_me;
      logic a_other;
      lat = 0;
      set_req(port, 1'b1, we, addr, wdata);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (c == kraj_at) bus.kraj = 1'b1;
         a_me    = port ? bus.ack1 : bus.ack0;
         a_other = port ? bus.ack0 : bus.ack1;
         if (a_me) begin
            lat = c;
            check("ack_rdata", bus.rdata, exp_rdata);
            check("ack_other", a_other, 0);
            check("ack_strobes", {bus.memread, bus.memwrite}, 0);
            check("ack_halted", bus.halted, (kraj_at != 0) ? 1 : 0);
            break;
         end
         if (we && c <= 4) begin
            i = c - 1;
            check("wr_strobes", {bus.memread, bus.memwrite}, 2'b01);
            check("wr_mar", bus.mar, {addr[7:2], 2'(i)});
            check("wr_byte", bus.writedata, 8'(wdata >> (8 * (3 - i))));
         end else if (!we && c <= 8) begin
            i = (c - 1) / 2;
            check("rd_strobes", {bus.memread, bus.memwrite}, (c % 2 == 1) ? 2'b10 : 2'b00);
            check("rd_mar", bus.mar, {addr[7:2], 2'(i)});
         end
      end
      check("ack_latency", lat, we ? 5 : 9);
      set_req(port, 1'b0, we, addr, wdata);
      bus.kraj = 1'b0;
      @(posedge clk);
      #1;
      a_me = port ? bus.ack1 : bus.ack0;
      check("ack_one_cycle", a_me, 0);
   endtask

   int   n;
   int   when_c[4];
   int   got[4];
   int   exp_g[3];

   initial begin
      total  = 0;
      passed = 0;
      rst_n  = 1'b0;
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      bus.memdata = 8'h00;

      vecs[0] = '{1'b0, 1'b1, 8'h10, 32'hA1B2C3D4, 32'h00000000};
      vecs[1] = '{1'b1, 1'b1, 8'h10, 32'h01020304, 32'h00000000};
      vecs[2] = '{1'b1, 1'b0, 8'h12, 32'h00000000, 32'h01020304};
      vecs[3] = '{1'b0, 1'b0, 8'h13, 32'h00000000, 32'h01020304};
      vecs[4] = '{1'b0, 1'b1, 8'hFC, 32'hDEADBEEF, 32'h01020304};
      vecs[5] = '{1'b1, 1'b0, 8'hFE, 32'h00000000, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 1'b1, 8'h00, 32'h5A5AA5A5, 32'hDEADBEEF};
      vecs[7] = '{1'b0, 1'b0, 8'h01, 32'h00000000, 32'h5A5AA5A5};

      do_reset(1'b1);

      foreach (vecs[k])
         run_txn(vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rdata, 0);

      // reset while the third byte of a write is on the bus
      set_req(1'b0, 1'b1, 1'b1, 8'h40, 32'h11223344);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_memwrite", bus.memwrite, 1);
      rst_n = 1'b0;
      set_req(1'b0, 1'b0, 1'b1, 8'h40, 32'h11223344);
      #1;
      check("midrst_memwrite", bus.memwrite, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_ack0", bus.ack0, 0);
      check("midrst_rdata", bus.rdata, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_txn(1'b0, 1'b1, 8'h40, 32'h55667788, 32'h00000000, 0);
      run_txn(1'b1, 1'b0, 8'h40, 32'h00000000, 32'h55667788, 0);

      // both ports requesting continuously
      do_reset(1'b0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g = '{0, 1, 0};
`else
      exp_g = '{1, 1, 1};
`endif
      set_req(1'b0, 1'b1, 1'b1, 8'h50, 32'h11111111);
      set_req(1'b1, 1'b1, 1'b1, 8'h60, 32'h22222222);
      n = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         #1;
         check("arb_dual_ack", bus.ack0 & bus.ack1, 0);
         if (bus.ack0 || bus.ack1) begin
            got[n]    = bus.ack1 ? 1 : 0;
            when_c[n] = c;
            n++;
            if (n == 3) begin
               bus.req0 = 1'b0;
               bus.req1 = 1'b0;
               break;
            end
         end
      end
      check("arb_count", n, 3);
      for (int k = 0; k < 3; k++) check("arb_grant", got[k], exp_g[k]);
      check("arb_third_ack_cycle", when_c[2], 17);
      @(posedge clk);
      #1;
      check("arb_idle_busy", bus.busy, 0);

      // back-to-back: req0 held across its first ack
      set_req(1'b0, 1'b1, 1'b1, 8'h70, 32'h0BADF00D);
      n = 0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         #1;
         if (bus.ack0) begin
            if (n < 4) when_c[n] = c;
            n++;
            if (n == 2) bus.req0 = 1'b0;
         end
      end
      check("b2b_count", n, 2);
      check("b2b_first", when_c[0], 5);
      check("b2b_second", when_c[1], 11);

      // end-of-program during a read, then no further grants
      run_txn(1'b1, 1'b0, 8'hFC, 32'h00000000, 32'hDEADBEEF, 4);
      check("halt_sticky", bus.halted, 1);
      set_req(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         check("halt_busy", bus.busy, 0);
         check("halt_ack0", bus.ack0, 0);
      end
      check("halt_still", bus.halted, 1);
      bus.req0 = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
